pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline sequencing controller for the RV32 core: it generates the stall and flush controls that hold or bubble the stage-1 and stage-2 pipeline registers and the PC. It resolves load-use hazards, taken-branch redirects, data-memory wait states and trap entry. It sits beside the decode stage, takes stage-1 decode fields and stage-2 status, and drives every pipeline-register enable/clear in the core.

## Interface
- `MEM_TIMEOUT`, default 255: number of consecutive `MEM_WAIT` cycles that raises `mem_err_out`.
- `TRAP_DRAIN`, default 2: number of flush cycles issued on trap entry (valid range 1-7).
- `clk_in` input 1: single core clock, rising edge.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `rs1_addr_in`, `rs2_addr_in` input 5: source registers of the instruction in stage 1.
- `rs1_used_in`, `rs2_used_in` input 1: the stage-1 instruction reads rs1 / rs2.
- `s2_rd_addr_in` input 5: destination register of the instruction in stage 2.
- `s2_load_in` input 1: stage 2 holds a load with `rf_wr_en` set.
- `branch_taken_in` input 1: stage 2 resolved a taken branch or jump.
- `dmem_req_in` input 1: stage 2 issues a data-memory access this cycle.
- `dmem_ready_in` input 1: data memory completes the access this cycle.
- `trap_req_in` input 1: trap/interrupt request, level-held until `trap_ack_out`.
- `pc_stall_out`, `s1_stall_out`, `s2_stall_out` output 1: hold the PC / stage-1 register / stage-2 register.
- `s1_flush_out`, `s2_flush_out` output 1: load a bubble (all zeros) into the stage-1 / stage-2 register.
- `trap_ack_out` output 1: one-cycle pulse marking trap entry.
- `mem_err_out` output 1: one-cycle pulse when the memory wait times out.
- `state_out` output 2: current FSM state, for debug.

## Operation
- FSM states: `RUN`=0, `MEM_WAIT`=1, `FLUSH`=2, `TRAP`=3.
- `RUN` events, evaluated in priority order:
  1. `trap_req_in`: go to `TRAP`, pulse `trap_ack_out`, assert both flushes.
  2. `dmem_req_in & !dmem_ready_in`: assert all three stalls, go to `MEM_WAIT`, clear the wait counter.
  3. `branch_taken_in`: assert `s1_flush_out`, go to `FLUSH`.
  4. Load-use hazard: assert `pc_stall_out` and `s1_stall_out` plus `s2_flush_out`, which inserts one bubble. State stays `RUN`.
  5. Otherwise: all outputs 0.
- Load-use hazard condition: `s2_load_in & s2_rd_addr_in!=0 & ((rs1_used_in & rs1_addr_in==s2_rd_addr_in) | (rs2_used_in & rs2_addr_in==s2_rd_addr_in))`.
- `MEM_WAIT`:
  - Assert all stalls while `!dmem_ready_in`; the wait counter increments each cycle.
  - When `dmem_ready_in` is seen, drop the stalls in that same cycle and return to `RUN`.
  - When the counter reaches `MEM_TIMEOUT`, pulse `mem_err_out`, assert both flushes and go to `TRAP`.
  - `trap_req_in` is ignored in this state; it is taken in `RUN` after completion.
- `FLUSH`: lasts one cycle and asserts `s1_flush_out`, covering the one-cycle imem redirect latency.
  - Next state is `RUN`.
  - If `trap_req_in` is high, go to `TRAP` instead and pulse `trap_ack_out`.
- `TRAP`: assert both flushes while the drain counter counts up to `TRAP_DRAIN`-1, then return to `RUN`.
  - The cycle that entered `TRAP` counts as drain cycle 0.
- A stall and a flush are never asserted on the same register; flush wins.
- `rs*_addr_in == 0` never raises a hazard.

## Timing
- Reset: state `RUN`, all counters 0, every output 0. Assertion is asynchronous; release is synchronous to `clk_in`.
- Reset mid-`MEM_WAIT` or mid-`TRAP` abandons the sequence immediately, with no pulse.
- Stall and flush outputs are combinational from the inputs and the current state, so there is zero-cycle latency to the pipeline registers.
- `trap_ack_out` and `mem_err_out` are registered? No: they are decoded from the state transition and last exactly one cycle.
- Load-use costs exactly 1 bubble. A taken branch costs 2 flushed slots. Trap entry costs `TRAP_DRAIN` cycles.

## Configuration
- `PIPE_HAZARD_CTRL_PERF_CNT_EN` defined: adds two outputs, each 32 bits, cleared on reset and wrapping at 2^32:
  - `stall_cnt_out` counts cycles with `pc_stall_out=1`.
  - `flush_cnt_out` counts cycles with either flush asserted.
- Undefined: both ports and both counters are absent.

## Structure
- `pipe_ctrl_pkg` holds the state encodings (`ST_RUN`, `ST_MEM_WAIT`, `ST_FLUSH`, `ST_TRAP`) and the default values of `MEM_TIMEOUT` and `TRAP_DRAIN`.
- One combinational sub-module, `load_use_detect`, holds the hazard compare. Its outputs are `hazard_out`, with `rs1_hit_out` and `rs2_hit_out` for debug.

## Test plan
- Load x5 in stage 2 while the stage-1 instruction reads x5 as rs2 with `rs2_used_in=1` -> exactly 1 cycle of `pc_stall_out`, `s1_stall_out` and `s2_flush_out`. The same case with x0 -> no stall.
- `branch_taken_in` pulsed for 1 cycle -> `s1_flush_out` high for 2 cycles, `state_out` sequence 0,2,0.
- `dmem_req_in=1` with `dmem_ready_in` arriving after 3 wait cycles -> stalls high for 3 cycles, low in the ready cycle, then `RUN`.
- `dmem_ready_in` held low with `MEM_TIMEOUT`=4 -> `mem_err_out` pulse at wait count 4, then 2 cycles of double flush, then `RUN`.
- `trap_req_in` together with `branch_taken_in` in `RUN` -> trap wins: `trap_ack_out` for 1 cycle, both flushes for 2 cycles.
- `rst_n_in` pulled low in `MEM_WAIT` -> all outputs 0 immediately and `state_out`=0. With `PIPE_HAZARD_CTRL_PERF_CNT_EN` defined, both counters read 0 after reset.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared state encodings and parameter defaults for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_TRAP     = 2'd3
    } state_t;

    localparam int DEF_MEM_TIMEOUT = 255;
    localparam int DEF_TRAP_DRAIN  = 2;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the stage-1 sources and the stage-2 load destination.
module load_use_detect (
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic       rs1_used_in,
    input  logic       rs2_used_in,
    input  logic [4:0] s2_rd_addr_in,
    input  logic       s2_load_in,
    output logic       hazard_out,
    output logic       rs1_hit_out,
    output logic       rs2_hit_out
);

    logic load_live;

    // x0 destination never produces data, so a match on it is not a hazard
    assign load_live   = s2_load_in & (s2_rd_addr_in != 5'd0);
    assign rs1_hit_out = load_live & rs1_used_in & (rs1_addr_in == s2_rd_addr_in);
    assign rs2_hit_out = load_live & rs2_used_in & (rs2_addr_in == s2_rd_addr_in);
    assign hazard_out  = rs1_hit_out | rs2_hit_out;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencing for the RV32 pipeline: load-use, branch redirect, dmem wait, trap entry.
// Optional PIPE_HAZARD_CTRL_PERF_CNT_EN adds stall/flush cycle counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int TRAP_DRAIN  = DEF_TRAP_DRAIN
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [4:0]  rs1_addr_in,
    input  logic [4:0]  rs2_addr_in,
    input  logic        rs1_used_in,
    input  logic        rs2_used_in,
    input  logic [4:0]  s2_rd_addr_in,
    input  logic        s2_load_in,
    input  logic        branch_taken_in,
    input  logic        dmem_req_in,
    input  logic        dmem_ready_in,
    input  logic        trap_req_in,
    output logic        pc_stall_out,
    output logic        s1_stall_out,
    output logic        s2_stall_out,
    output logic        s1_flush_out,
    output logic        s2_flush_out,
    output logic        trap_ack_out,
    output logic        mem_err_out,
`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
    output logic [31:0] stall_cnt_out,
    output logic [31:0] flush_cnt_out,
`endif
    output logic [1:0]  state_out
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    state_t         state, state_nxt;
    logic [WCW-1:0] wait_cnt, wait_nxt;
    logic [2:0]     drain_cnt, drain_nxt;
    logic           lu_hazard, lu_rs1_hit, lu_rs2_hit, load_use;
    logic           pc_st, s1_st, s2_st, s1_fl, s2_fl, ack, err;

    load_use_detect u_lud (
        .rs1_addr_in   (rs1_addr_in),
        .rs2_addr_in   (rs2_addr_in),
        .rs1_used_in   (rs1_used_in),
        .rs2_used_in   (rs2_used_in),
        .s2_rd_addr_in (s2_rd_addr_in),
        .s2_load_in    (s2_load_in),
        .hazard_out    (lu_hazard),
        .rs1_hit_out   (lu_rs1_hit),
        .rs2_hit_out   (lu_rs2_hit)
    );

    assign load_use = lu_hazard & (lu_rs1_hit | lu_rs2_hit);

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        drain_nxt = drain_cnt;
        pc_st = 1'b0; s1_st = 1'b0; s2_st = 1'b0;
        s1_fl = 1'b0; s2_fl = 1'b0; ack = 1'b0; err = 1'b0;
        // Trap entry cycle is drain cycle 0; the TRAP state covers cycles 1..TRAP_DRAIN-1
        unique case (state)
            ST_RUN: begin
                if (trap_req_in) begin
                    ack = 1'b1; s1_fl = 1'b1; s2_fl = 1'b1;
                    state_nxt = (TRAP_DRAIN > 1) ? ST_TRAP : ST_RUN;
                    drain_nxt = 3'd1;
                end else if (dmem_req_in && !dmem_ready_in) begin
                    pc_st = 1'b1; s1_st = 1'b1; s2_st = 1'b1;
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = '0;
                end else if (branch_taken_in) begin
                    s1_fl = 1'b1;
                    state_nxt = ST_FLUSH;
                end else if (load_use) begin
                    pc_st = 1'b1; s1_st = 1'b1; s2_fl = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready_in) begin
                    state_nxt = ST_RUN;
                end else if (wait_cnt == WCW'(MEM_TIMEOUT)) begin
                    err = 1'b1; s1_fl = 1'b1; s2_fl = 1'b1;
                    state_nxt = (TRAP_DRAIN > 1) ? ST_TRAP : ST_RUN;
                    drain_nxt = 3'd1;
                end else begin
                    pc_st = 1'b1; s1_st = 1'b1; s2_st = 1'b1;
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            ST_FLUSH: begin
                s1_fl = 1'b1;
                state_nxt = ST_RUN;
                if (trap_req_in) begin
                    ack = 1'b1; s2_fl = 1'b1;
                    state_nxt = (TRAP_DRAIN > 1) ? ST_TRAP : ST_RUN;
                    drain_nxt = 3'd1;
                end
            end
            ST_TRAP: begin
                s1_fl = 1'b1; s2_fl = 1'b1;
                if (drain_cnt >= 3'(TRAP_DRAIN - 1)) begin
                    state_nxt = ST_RUN;
                    drain_nxt = 3'd0;
                end else begin
                    drain_nxt = drain_cnt + 3'd1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Outputs are forced low while reset is held, independent of the inputs
    assign pc_stall_out = rst_n_in & pc_st;
    assign s1_stall_out = rst_n_in & s1_st & ~s1_fl;
    assign s2_stall_out = rst_n_in & s2_st & ~s2_fl;
    assign s1_flush_out = rst_n_in & s1_fl;
    assign s2_flush_out = rst_n_in & s2_fl;
    assign trap_ack_out = rst_n_in & ack;
    assign mem_err_out  = rst_n_in & err;
    assign state_out    = state;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            drain_cnt <= drain_nxt;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stall_cnt_out <= '0;
            flush_cnt_out <= '0;
        end else begin
            if (pc_stall_out)                 stall_cnt_out <= stall_cnt_out + 32'd1;
            if (s1_flush_out || s2_flush_out) flush_cnt_out <= flush_cnt_out + 32'd1;
        end
    end
`endif

endmodule
